keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Parametrised matrix-keypad front end: row scan, 2-flop column sync, press/release debounce, key encode.
//  Holds the last DEPTH digits in a shift buffer; START and CLEAR are command keys, never stored.
//  Sits between the keypad pins and the game FSM; emits one-cycle key/command strobes.
// PARAMETERS
//  ROWS            4        keypad rows driven (one-hot scan)
//  COLS            3        keypad columns sampled
//  CODE_W          4        key code width
//  DEPTH           2        digits held in buffer
//  SETTLE_CYCLES   4        cycles a row is driven before its columns are sampled (>=1)
//  DEBOUNCE_CYCLES 1000000  stable cycles required to accept a press or a release (>=2)
//  REPEAT_CYCLES   8000000  hold time per auto-repeat (KEYPAD_REPEAT_EN only)
// PORTS
//  clk          in   1               system clock
//  rst          in   1               asynchronous, active-high reset
//  kb_cols      in   COLS            raw column lines, active-high, asynchronous
//  kb_rows      out  ROWS            one-hot row drive
//  key_valid    out  1               1-cycle strobe: debounced press accepted
//  key_code     out  CODE_W          code of last accepted key; stable until next key_valid
//  key_held     out  1               high while accepted key is still down (HELD state)
//  digits       out  DEPTH*CODE_W    digit buffer; newest in [CODE_W-1:0]
//  digit_count  out  $clog2(DEPTH+1) digits stored, saturates at DEPTH
//  start_game   out  1               1-cycle strobe on accepted START key
//  clear_pulse  out  1               1-cycle strobe on accepted CLEAR key
// BEHAVIOUR
//  Reset: kb_rows=1 (row 0); all strobes 0; key_code=0; key_held=0; digits=0; digit_count=0; FSM=SCAN.
//  Sync: kb_cols through 2 flops -> cols_s; all decisions use cols_s (2-cycle input latency).
//  FSM SCAN: row held SETTLE_CYCLES; then cols_s==0 -> rotate left (row ROWS-1 wraps to 0), else DEBOUNCE.
//  DEBOUNCE: row frozen; latch col = lowest set bit of cols_s; count while that bit stays high.
//    Bit drops before DEBOUNCE_CYCLES -> SCAN (same row, settle restarts), no strobe.
//    Count reaches DEBOUNCE_CYCLES -> key_valid for 1 cycle, key_code updated same cycle, -> HELD.
//  HELD: key_held=1; cols_s==0 -> RELEASE.
//  RELEASE: count cycles with cols_s==0; any column high -> restart count, stay RELEASE.
//    Count reaches DEBOUNCE_CYCLES -> SCAN; row advances to next row.
//  Encode: idx=row*COLS+col; lut gives code. Default 4x3: idx0-8 -> 1-9, 9 -> CLEAR(0xA), 10 -> 0, 11 -> START(0xB).
//    idx >= lut size -> code 0xF, key_valid still pulses, buffer untouched.
//  Buffer (same cycle as key_valid, visible next cycle):
//    digit (code<=9): shift buffer toward MSB, insert at LSB slot; oldest dropped; digit_count+1, saturates at DEPTH.
//    CLEAR: digits=0, digit_count=0, clear_pulse=1.  START: start_game=1; buffer and count unchanged.
//  Multiple keys: lowest column of the active row wins; other rows ignored until RELEASE completes.
//  Reset mid-operation: immediate return to reset state; key still down is re-debounced as a new press.
//  Counters sized $clog2(max count+1); no wrap, cleared on every state entry.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: in HELD, each REPEAT_CYCLES of continuous hold re-issues key_valid
//    with same key_code and same buffer/command action (CLEAR/START repeat too); counter clears on entering HELD.
//  KEYPAD_REPEAT_EN undefined: exactly one key_valid per press; REPEAT_CYCLES unused, no repeat counter.
// STRUCTURE
//  Package keypad_pkg: CODE_W-wide constants KEY_CLEAR=4'hA, KEY_START=4'hB, KEY_NONE=4'hF; FSM state
//    encoding (SCAN, DEBOUNCE, HELD, RELEASE); default 4x3 code table as a function.
//  Sub-module keypad_code_lut (combinational row/col -> code) kept separate so layouts swap without touching FSM.
//  Buffer uses existing reg4Bit cells per slot when CODE_W==4, else inline registers.
// TESTING (sim: DEBOUNCE_CYCLES=8, SETTLE_CYCLES=2, REPEAT_CYCLES=20, 4x3, DEPTH=2)
//  Idle, cols=0 -> kb_rows cycles 1,2,4,8,1 every 2 cycles; no strobes.
//  Clean press row1/col2 (idx5) held 40 cycles -> one key_valid, key_code=6, digits=0x06, count=1.
//  Press "3","7","9" -> digits=0x79, count=2 (saturated); CLEAR -> clear_pulse, digits=0, count=0.
//  Glitch col high 5 cycles then low -> no key_valid, FSM back to SCAN same row; bounce on release resets release count.
//  START (idx11) -> start_game 1 cycle, digits unchanged; rst asserted mid-DEBOUNCE -> outputs at reset values.
//  KEYPAD_REPEAT_EN: hold "5" 8+45 cycles -> key_valid at accept, +20, +40; without macro -> exactly one.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, scanner FSM encoding and the default 4x3 code table.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_START = 4'hB;
  localparam logic [3:0] KEY_NONE  = 4'hF;

  localparam int unsigned DEFAULT_LUT_SIZE = 12;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  // Telephone-style 4x3 layout: 1-9 on the top rows, then CLEAR, 0, START.
  function automatic logic [3:0] default_code(input int unsigned idx);
    logic [3:0] code;
    if (idx <= 32'd8) begin
      code = 4'(idx + 32'd1);
    end else if (idx == 32'd9) begin
      code = KEY_CLEAR;
    end else if (idx == 32'd10) begin
      code = 4'h0;
    end else if (idx == 32'd11) begin
      code = KEY_START;
    end else begin
      code = KEY_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_code_lut.sv
// keypad_code_lut: combinational row/column to key code; swap this file to change layouts.
module keypad_code_lut
  import keypad_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 3,
  parameter int CODE_W = 4,
  parameter int ROW_W  = 2,
  parameter int COL_W  = 2
) (
  input  logic [ROW_W-1:0]  row_i,
  input  logic [COL_W-1:0]  col_i,
  output logic [CODE_W-1:0] code_o
);

  int unsigned idx;
  logic [3:0]  code4;

  always_comb begin
    idx   = 32'(row_i) * 32'(COLS) + 32'(col_i);
    code4 = (idx < DEFAULT_LUT_SIZE) ? default_code(idx) : KEY_NONE;
    code_o = CODE_W'(code4);
  end

endmodule

// File: rtl/reg4Bit.sv
// reg4Bit: 4-bit load-enable register cell used for each digit slot.
module reg4Bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= 4'h0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scan, 2-flop column sync, press/release debounce, encode, digit buffer.
// Define KEYPAD_REPEAT_EN to re-issue key_valid every REPEAT_CYCLES while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 3,
  parameter int CODE_W          = 4,
  parameter int DEPTH           = 2,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 8000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COLS-1:0]            kb_cols,
  output logic [ROWS-1:0]            kb_rows,
  output logic                       key_valid,
  output logic [CODE_W-1:0]          key_code,
  output logic                       key_held,
  output logic [DEPTH*CODE_W-1:0]    digits,
  output logic [$clog2(DEPTH+1)-1:0] digit_count,
  output logic                       start_game,
  output logic                       clear_pulse
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DCNT_W  = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(ROWS - 1);
  localparam logic [DCNT_W-1:0] DCNT_FULL   = DCNT_W'(DEPTH);

  if (SETTLE_CYCLES < 1 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scanner: SETTLE_CYCLES>=1, DEBOUNCE_CYCLES>=2, REPEAT_CYCLES>=1 required");
  end

  // ------------------------------------------------------------------
  // Column synchroniser. The driven row index travels alongside the
  // columns so every synchronised sample knows which row produced it.
  // ------------------------------------------------------------------
  logic [COLS-1:0]  cols_m_q, cols_s_q;
  logic [ROW_W-1:0] tag_m_q, tag_s_q;
  logic [ROW_W-1:0] row_q, row_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cols_m_q <= '0;
      cols_s_q <= '0;
      tag_m_q  <= '0;
      tag_s_q  <= '0;
    end else begin
      cols_m_q <= kb_cols;
      cols_s_q <= cols_m_q;
      tag_m_q  <= row_q;
      tag_s_q  <= tag_m_q;
    end
  end

  // ------------------------------------------------------------------
  // Scan / debounce FSM
  // ------------------------------------------------------------------
  kp_state_e         state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              start_q, start_d;
  logic              clear_q, clear_d;
  logic [COL_W-1:0]  low_col;
  logic [ROW_W-1:0]  next_row;
  logic [CODE_W-1:0] lut_code;
  logic              tag_match;
  logic              accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q, rep_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  keypad_code_lut #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .CODE_W(CODE_W),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_lut (
    .row_i (row_q),
    .col_i (col_q),
    .code_o(lut_code)
  );

  always_comb begin
    low_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (cols_s_q[c]) begin
        low_col = COL_W'(c);
      end
    end
  end

  assign next_row  = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
  assign tag_match = (tag_s_q == row_q);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    start_d     = 1'b0;
    clear_d     = 1'b0;
    accept      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif

    unique case (state_q)
      ST_SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (cols_s_q == '0) begin
            row_d = next_row;
          end else begin
            // The hit belongs to the row that was driven when it was sampled,
            // which lags the current drive by the synchroniser depth.
            state_d = ST_DEBOUNCE;
            row_d   = tag_s_q;
            col_d   = low_col;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (tag_match) begin
          if (!cols_s_q[col_q]) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            accept  = 1'b1;
            state_d = ST_HELD;
            cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_HELD: begin
        if (cols_s_q == '0) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_q == REP_LAST) begin
          accept = 1'b1;
          rep_d  = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
`endif
      end

      ST_RELEASE: begin
        if (cols_s_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          row_d   = next_row;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = lut_code;
      start_d     = (lut_code == CODE_W'(KEY_START));
      clear_d     = (lut_code == CODE_W'(KEY_CLEAR));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      start_q     <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      start_q     <= start_d;
      clear_q     <= clear_d;
    end
  end

  // ------------------------------------------------------------------
  // Digit buffer: acts on the strobed code, so it is visible one cycle
  // after key_valid. Slot 0 holds the newest digit.
  // ------------------------------------------------------------------
  logic [DEPTH-1:0][CODE_W-1:0] slot_q, slot_d;
  logic [DCNT_W-1:0]            dcnt_q;
  logic                         is_digit, is_clear, buf_en;

  assign is_digit = (key_code_q <= CODE_W'(9));
  assign is_clear = (key_code_q == CODE_W'(KEY_CLEAR));
  assign buf_en   = key_valid_q && (is_digit || is_clear);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    if (gi == 0) begin : g_first
      assign slot_d[gi] = is_clear ? '0 : key_code_q;
    end else begin : g_rest
      assign slot_d[gi] = is_clear ? '0 : slot_q[gi-1];
    end

    if (CODE_W == 4) begin : g_cell
      reg4Bit u_reg (
        .clk (clk),
        .rst (rst),
        .en_i(buf_en),
        .d_i (slot_d[gi]),
        .q_o (slot_q[gi])
      );
    end else begin : g_inline
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_q[gi] <= '0;
        end else if (buf_en) begin
          slot_q[gi] <= slot_d[gi];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q <= '0;
    end else if (key_valid_q) begin
      if (is_clear) begin
        dcnt_q <= '0;
      end else if (is_digit && dcnt_q != DCNT_FULL) begin
        dcnt_q <= dcnt_q + 1'b1;
      end
    end
  end

  assign kb_rows     = ROWS'(1) << row_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_held    = (state_q == ST_HELD);
  assign digits      = slot_q;
  assign digit_count = dcnt_q;
  assign start_game  = start_q;
  assign clear_pulse = clear_q;

endmodule
